// File: rtl/timed_event_queue.sv
// Timestamped command queue for the RTIO clock domain: holds {timestamp, data}
// entries in write order and releases the head once the shared counter reaches it.
module timed_event_queue #(
   parameter int DATA_WIDTH      = 32,
   parameter int FIFO_DEPTH      = 16,
   parameter int FIFO_ADDR_WIDTH = 4
) (
   input  logic                     rtio_clk,
   input  logic                     reset,
   input  logic                     auto_start,
   input  logic [63:0]              counter,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [63:0]              in_timestamp,
   input  logic [DATA_WIDTH-1:0]    in_data,
   output logic                     out_valid,
   output logic [63:0]              out_timestamp,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     late,
   output logic                     late_sticky,
   input  logic                     late_clear,
   output logic [FIFO_ADDR_WIDTH:0] fifo_count
);

   localparam logic [FIFO_ADDR_WIDTH:0] FULL_COUNT = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);

   logic [63:0]                ts_mem   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]      data_mem [FIFO_DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
   logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
   logic [63:0]                head_ts;
   logic [DATA_WIDTH-1:0]      head_data;
   logic                       do_write;
   logic                       do_fire;
   logic                       fire_late;

   // First-word fall-through: the head entry is visible without a read cycle.
   assign head_ts   = ts_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   // Registered count only, so a same-cycle pop never frees room for a write.
   assign in_ready = !reset && (fifo_count != FULL_COUNT);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      do_write  = 1'b0;
      do_fire   = 1'b0;
      fire_late = 1'b0;
      if (in_valid && in_ready)
         do_write = 1'b1;
      if (auto_start && (fifo_count != '0) && (counter >= head_ts)) begin
         do_fire   = 1'b1;
         fire_late = (counter > head_ts);
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count decide what is valid.
   always_ff @(posedge rtio_clk) begin
      if (do_write) begin
         ts_mem[wr_ptr]   <= in_timestamp;
         data_mem[wr_ptr] <= in_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge rtio_clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (do_write)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_fire)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_write, do_fire})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Event strobes pulse for one cycle; timestamp and payload hold until the next release.
   always_ff @(posedge rtio_clk) begin
      if (reset) begin
         out_valid     <= 1'b0;
         out_timestamp <= '0;
         out_data      <= '0;
         late          <= 1'b0;
         late_sticky   <= 1'b0;
      end else begin
         out_valid <= do_fire;
         late      <= fire_late;
         if (do_fire) begin
            out_timestamp <= head_ts;
            out_data      <= head_data;
         end
         if (fire_late)
            late_sticky <= 1'b1;
         else if (late_clear)
            late_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_timed_event_queue.sv
// Scoreboard bench for timed_event_queue: a queue-based reference model predicts
// each release, and expected events are popped and compared as the DUT emits them.
module tb_timed_event_queue;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   typedef struct {
      logic [63:0]   ts;
      logic [DW-1:0] data;
   } entry_t;

   typedef struct {
      logic [63:0]   ts;
      logic [DW-1:0] data;
      logic          late;
   } event_t;

   logic            rtio_clk = 1'b0;
   logic            reset = 1'b1;
   logic            auto_start = 1'b0;
   logic [63:0]     counter = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [63:0]     in_timestamp = '0;
   logic [DW-1:0]   in_data = '0;
   logic            out_valid;
   logic [63:0]     out_timestamp;
   logic [DW-1:0]   out_data;
   logic            late;
   logic            late_sticky;
   logic            late_clear = 1'b0;
   logic [AW:0]     fifo_count;

   entry_t          model_q[$];
   event_t          exp_q[$];
   logic            exp_valid = 1'b0;
   logic            exp_sticky = 1'b0;
   logic [63:0]     hold_ts = '0;
   logic [DW-1:0]   hold_data = '0;

   int              vectors = 0;
   int              miscompares = 0;
   int              ev_count = 0;
   logic [63:0]     last_fire_ctr = '0;
   logic            last_late = 1'b0;

   timed_event_queue #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FIFO_ADDR_WIDTH(AW)
   ) dut (
      .rtio_clk     (rtio_clk),
      .reset        (reset),
      .auto_start   (auto_start),
      .counter      (counter),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_timestamp (in_timestamp),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_timestamp(out_timestamp),
      .out_data     (out_data),
      .late         (late),
      .late_sticky  (late_sticky),
      .late_clear   (late_clear),
      .fifo_count   (fifo_count)
   );

   always #5 rtio_clk = ~rtio_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (counter=%0d)", tag, got, exp, counter);
      end
   endtask

   // One clock cycle: predict from the current inputs, clock the DUT, compare at the falling edge.
   task automatic step();
      logic        m_ready;
      logic        m_fire;
      logic        m_late;
      logic [63:0] fire_ctr;
      entry_t      head;
      entry_t      ent;
      event_t      ev;
      #1;
      m_ready = !reset && (model_q.size() != DEPTH);
      check("in_ready", in_ready, m_ready);
      m_fire = 1'b0;
      m_late = 1'b0;
      fire_ctr = counter;
      if (!reset && auto_start && model_q.size() != 0 && counter >= model_q[0].ts) begin
         m_fire = 1'b1;
         m_late = counter > model_q[0].ts;
      end
      if (reset) begin
         model_q.delete();
         exp_q.delete();
         exp_sticky = 1'b0;
         hold_ts = '0;
         hold_data = '0;
         exp_valid = 1'b0;
      end else begin
         if (m_fire) begin
            head = model_q.pop_front();
            ev.ts = head.ts;
            ev.data = head.data;
            ev.late = m_late;
            exp_q.push_back(ev);
            hold_ts = head.ts;
            hold_data = head.data;
         end
         if (in_valid && m_ready) begin
            ent.ts = in_timestamp;
            ent.data = in_data;
            model_q.push_back(ent);
         end
         if (m_late)
            exp_sticky = 1'b1;
         else if (late_clear)
            exp_sticky = 1'b0;
         exp_valid = m_fire;
      end
      @(posedge rtio_clk);
      @(negedge rtio_clk);
      check("out_valid", out_valid, exp_valid);
      if (out_valid && exp_q.size() != 0) begin
         ev = exp_q.pop_front();
         check("out_timestamp", out_timestamp, ev.ts);
         check("out_data", out_data, ev.data);
         check("late", late, ev.late);
         ev_count++;
         last_fire_ctr = fire_ctr;
         last_late = late;
      end else begin
         check("late_idle", late, 1'b0);
         check("ts_hold", out_timestamp, hold_ts);
         check("data_hold", out_data, hold_data);
         exp_q.delete();
      end
      check("fifo_count", fifo_count, model_q.size());
      check("late_sticky", late_sticky, exp_sticky);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         counter++;
      end
   endtask

   task automatic write(input logic [63:0] ts, input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_timestamp = ts;
      in_data = d;
      step();
      counter++;
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset held three cycles while a command is offered: nothing is written.
      reset = 1'b1;
      in_valid = 1'b1;
      in_timestamp = 64'd7;
      in_data = 32'h1;
      for (int i = 0; i < 3; i++) step();
      check("rst_count", fifo_count, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_ts", out_timestamp, 0);
      check("rst_out_data", out_data, 0);
      check("rst_late", late, 0);
      check("rst_sticky", late_sticky, 0);
      reset = 1'b0;
      in_valid = 1'b0;
      #1;
      check("ready_after_rst", in_ready, 1);
      run(1);

      // On-time release of a single event.
      auto_start = 1'b1;
      counter = 0;
      run(10);
      ev_count = 0;
      write(64'd100, 32'hA5);
      run(95);
      check("t2_events", ev_count, 1);
      check("t2_fire_ctr", last_fire_ctr, 100);
      check("t2_late", last_late, 0);

      // Late event (counter also steps backwards here), then sticky clear.
      counter = 50;
      ev_count = 0;
      write(64'd5, 32'h5A);
      run(1);
      check("t3_events", ev_count, 1);
      check("t3_fire_ctr", last_fire_ctr, 51);
      check("t3_late", last_late, 1);
      run(3);
      check("t3_sticky_held", late_sticky, 1);
      late_clear = 1'b1;
      run(1);
      late_clear = 1'b0;
      run(2);
      check("t3_sticky_clr", late_sticky, 0);

      // Full queue with release disabled, rejected 17th offer, then in-order drain.
      auto_start = 1'b0;
      counter = 280;
      for (int i = 0; i < 16; i++) write(64'd300 + 64'(i), 32'h100 + 32'(i));
      run(2);
      check("t4_full_count", fifo_count, 16);
      check("t4_full_ready", in_ready, 0);
      write(64'd999, 32'hDEAD);
      check("t4_no_accept", fifo_count, 16);
      counter = 290;
      auto_start = 1'b1;
      ev_count = 0;
      run(30);
      check("t4_events", ev_count, 16);
      check("t4_last_fire", last_fire_ctr, 315);
      check("t4_empty", fifo_count, 0);

      // Back-to-back releases.
      counter = 195;
      ev_count = 0;
      write(64'd200, 32'hB0);
      write(64'd201, 32'hB1);
      write(64'd202, 32'hB2);
      run(10);
      check("t5_events", ev_count, 3);
      check("t5_last_fire", last_fire_ctr, 202);

      // Equal timestamps: followers report late.
      counter = 217;
      for (int i = 0; i < 3; i++) write(64'd220, 32'hC0 + 32'(i));
      run(5);
      check("same_ts_last_late", last_late, 1);

      // Written one tick before its timestamp: fires on time.
      counter = 229;
      write(64'd230, 32'hD0);
      run(3);
      check("just_in_time_ctr", last_fire_ctr, 230);
      check("just_in_time_late", last_late, 0);

      // Streaming writes overlapping with pops.
      counter = 250;
      for (int i = 0; i < 5; i++) write(counter + 64'd1, 32'hE0 + 32'(i));
      run(4);

      // A smaller timestamp behind a larger one waits, then fires late.
      counter = 260;
      write(64'd270, 32'hF0);
      write(64'd265, 32'hF1);
      run(15);
      check("reorder_late", last_late, 1);

      // Reset mid-operation discards queued entries.
      counter = 490;
      write(64'd1000, 32'h10);
      write(64'd1001, 32'h11);
      write(64'd1002, 32'h12);
      run(7);
      reset = 1'b1;
      step();
      counter++;
      reset = 1'b0;
      check("t6_count", fifo_count, 0);
      ev_count = 0;
      run(600);
      check("t6_no_events", ev_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
